// File: rtl/heat_grid_solver.sv
// rtl/heat_grid_solver.sv - Jacobi four-neighbour heat-diffusion solver with double-buffered cell banks
module heat_grid_solver #(
  parameter int GRID_W = 5,
  parameter int GRID_H = 5,
  parameter int DATA_W = 4,
  parameter int ADDR_W = 6,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [ITER_W-1:0] cmd_iters,
  input  logic              cmd_bmode,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_count
);
  localparam int N     = GRID_W * GRID_H;
  localparam int IDX_W = $clog2(N);
  localparam int ROW_W = $clog2(GRID_H);
  localparam int COL_W = $clog2(GRID_W);
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RUN   = 2'b11;

  typedef enum logic [1:0] {IDLE, SWEEP, SWAP} state_t;
  state_t state, state_next;

  logic [DATA_W-1:0] bank_a [0:N-1];
  logic [DATA_W-1:0] bank_b [0:N-1];
  logic              cur;
  logic [IDX_W-1:0]  idx;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [ITER_W-1:0] iters_lat;
  logic              bmode_lat;

  logic              accept, in_range, last_cell, last_iter, last_col, on_edge;
  logic [IDX_W-1:0]  addr_idx, n_idx, s_idx, w_idx, e_idx;
  logic [DATA_W-1:0] c_self, c_n, c_s, c_w, c_e, avg, new_val;
  logic [DATA_W+1:0] sum;

  assign cmd_ready = (state == IDLE) & ~rst;
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign in_range  = ({1'b0, cmd_addr} < (ADDR_W+1)'(N));
  assign addr_idx  = IDX_W'(cmd_addr);
  assign last_cell = (idx == IDX_W'(N - 1));
  assign last_iter = ((iter_count + ITER_W'(1)) == iters_lat);
  assign last_col  = (col == COL_W'(GRID_W - 1));
  assign on_edge   = (row == '0) || (row == ROW_W'(GRID_H - 1)) || (col == '0) || last_col;

  // A missing neighbour resolves to the cell itself, which is exactly the insulated rule;
  // fixed mode never uses the average on edge cells, so the substitution is harmless there.
  assign n_idx = (row == '0) ? idx : idx - IDX_W'(GRID_W);
  assign s_idx = (row == ROW_W'(GRID_H - 1)) ? idx : idx + IDX_W'(GRID_W);
  assign w_idx = (col == '0) ? idx : idx - IDX_W'(1);
  assign e_idx = last_col ? idx : idx + IDX_W'(1);

  always_comb begin
    c_self = cur ? bank_b[idx]   : bank_a[idx];
    c_n    = cur ? bank_b[n_idx] : bank_a[n_idx];
    c_s    = cur ? bank_b[s_idx] : bank_a[s_idx];
    c_w    = cur ? bank_b[w_idx] : bank_a[w_idx];
    c_e    = cur ? bank_b[e_idx] : bank_a[e_idx];
    sum    = {2'b00, c_n} + {2'b00, c_s} + {2'b00, c_w} + {2'b00, c_e};
    avg    = DATA_W'(sum >> 2);
    new_val = (!bmode_lat && on_edge) ? c_self : avg;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && cmd_op == OP_RUN && cmd_iters != '0) state_next = SWEEP;
      SWEEP:   if (last_cell) state_next = SWAP;
      SWAP:    state_next = last_iter ? IDLE : SWEEP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        bank_a[i] <= '0;
        bank_b[i] <= '0;
      end
      cur        <= 1'b0;
      idx        <= '0;
      row        <= '0;
      col        <= '0;
      iters_lat  <= '0;
      bmode_lat  <= 1'b0;
      iter_count <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      done       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          case (cmd_op)
            OP_WRITE: if (in_range) begin
              if (cur) bank_b[addr_idx] <= cmd_wdata;
              else     bank_a[addr_idx] <= cmd_wdata;
            end
            OP_READ: begin
              rd_valid <= 1'b1;
              if (!in_range) rd_data <= '0;
              else           rd_data <= cur ? bank_b[addr_idx] : bank_a[addr_idx];
            end
            OP_RUN: begin
              iters_lat  <= cmd_iters;
              bmode_lat  <= cmd_bmode;
              iter_count <= '0;
              idx        <= '0;
              row        <= '0;
              col        <= '0;
              if (cmd_iters == '0) done <= 1'b1;
            end
            default: ;
          endcase
        end
        SWEEP: begin
          if (cur) bank_a[idx] <= new_val;
          else     bank_b[idx] <= new_val;
          idx <= idx + IDX_W'(1);
          if (last_col) begin
            col <= '0;
            row <= row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end
        SWAP: begin
          cur        <= ~cur;
          iter_count <= iter_count + ITER_W'(1);
          idx        <= '0;
          row        <= '0;
          col        <= '0;
          if (last_iter) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_heat_grid_solver.sv
// tb/tb_heat_grid_solver.sv - directed self-checking bench for heat_grid_solver
module tb_heat_grid_solver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [5:0] cmd_addr = '0;
  logic [3:0] cmd_wdata = '0;
  logic [7:0] cmd_iters = '0;
  logic       cmd_bmode = 1'b0;
  logic       rd_valid;
  logic [3:0] rd_data;
  logic       busy;
  logic       done;
  logic [7:0] iter_count;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_cells [0:24];

  heat_grid_solver dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_iters(cmd_iters), .cmd_bmode(cmd_bmode), .rd_valid(rd_valid),
    .rd_data(rd_data), .busy(busy), .done(done), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] addr, input logic [3:0] wd,
                       input logic [7:0] it, input logic bm);
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_iters = it; cmd_bmode = bm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
  endtask

  task automatic read_chk(input logic [5:0] addr, input logic [3:0] exp);
    issue(2'b10, addr, 4'd0, 8'd0, 1'b0);
    @(negedge clk);
    check($sformatf("rd_valid[%0d]", addr), rd_valid, 1);
    check($sformatf("rd_data[%0d]", addr), rd_data, exp);
  endtask

  task automatic read_all(input string tag);
    int bad = 0;
    for (int i = 0; i < 25; i++) begin
      issue(2'b10, 6'(i), 4'd0, 8'd0, 1'b0);
      @(negedge clk);
      check($sformatf("%s cell %0d", tag, i), rd_data, exp_cells[i]);
    end
  endtask

  task automatic fill(input logic [3:0] v);
    for (int i = 0; i < 25; i++) begin
      issue(2'b01, 6'(i), v, 8'd0, 1'b0);
      exp_cells[i] = v;
    end
  endtask

  task automatic run(input logic [7:0] k, input logic bm, input int exp_busy, input bit probe);
    int busy_cyc = 0;
    int dones = 0;
    issue(2'b11, 6'd0, 4'd0, k, bm);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cyc++;
      if (done) dones++;
      if (probe && busy_cyc == 10) begin
        cmd_op = 2'b10; cmd_addr = 6'd3; cmd_valid = 1'b1;
        check("cmd_ready while busy", cmd_ready, 0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_op = 2'b00;
        @(negedge clk);
        check("rd_valid while busy", rd_valid, 0);
        busy_cyc++;
      end
    end
    check("busy cycles", busy_cyc, exp_busy);
    check("done during busy", dones, 0);
    check("done pulse", done, 1);
    check("cmd_ready at done", cmd_ready, 1);
    check("iter_count", iter_count, k);
    @(negedge clk);
    check("done one cycle", done, 0);
  endtask

  initial begin
    int waited;
    int late_done;
    @(negedge clk);
    check("cmd_ready in reset", cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset cmd_ready", cmd_ready, 1);
    check("reset rd_valid", rd_valid, 0);
    check("reset rd_data", rd_data, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset iter_count", iter_count, 0);

    // write/read and out-of-range read
    issue(2'b01, 6'd12, 4'd10, 8'd0, 1'b0);
    read_chk(6'd12, 4'd10);
    @(negedge clk);
    check("rd_valid pulse", rd_valid, 0);
    check("rd_data hold", rd_data, 10);
    read_chk(6'd40, 4'd0);
    issue(2'b01, 6'd40, 4'd7, 8'd0, 1'b0);
    read_chk(6'd40, 4'd0);

    // fixed mode, single hot interior cell
    for (int i = 0; i < 25; i++) exp_cells[i] = 4'd0;
    exp_cells[7] = 4'd2; exp_cells[11] = 4'd2; exp_cells[13] = 4'd2; exp_cells[17] = 4'd2;
    run(8'd1, 1'b0, 26, 1'b0);
    read_all("fixed");

    // insulated mode, hot corner
    fill(4'd0);
    issue(2'b01, 6'd0, 4'd8, 8'd0, 1'b0);
    exp_cells[0] = 4'd4; exp_cells[1] = 4'd2; exp_cells[5] = 4'd2;
    run(8'd1, 1'b1, 26, 1'b0);
    read_all("insulated");

    // saturation: all 15 stays 15 in both modes
    fill(4'd15);
    run(8'd3, 1'b0, 78, 1'b1);
    read_all("sat fixed");
    run(8'd3, 1'b1, 78, 1'b1);
    read_all("sat insulated");

    // zero-iteration run
    run(8'd0, 1'b0, 0, 1'b0);
    read_chk(6'd0, 4'd15);
    read_chk(6'd24, 4'd15);

    // reset during iteration 2 of a 5-iteration run
    issue(2'b11, 6'd0, 4'd0, 8'd5, 1'b0);
    waited = 0;
    while (iter_count != 8'd1 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("reached iteration 2", iter_count, 1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst iter_count", iter_count, 0);
    check("rst cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    late_done = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    check("no done after rst", late_done, 0);
    for (int i = 0; i < 25; i++) exp_cells[i] = 4'd0;
    read_all("after rst");
    check("iter_count after rst", iter_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
